fleet_engine: RTL

- Parametrised game-control core for the invader game.
- Owns the enemy-formation position (sweep, edge reverse, descend) and picks which living enemy fires, using an LFSR with round-robin fallback.
- Runs the sticky RUNNING/WIN/LOSE state machine and generates the restart pulse.
- Sits between the input/collision logic (enemy_alive, player_alive, button) and the renderer and enemy-shot modules.

---
 rtl/fleet_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fleet_engine.sv
// Invader game-control core: formation sweep/descend, LFSR-seeded round-robin
// shooter selection, sticky RUNNING/WIN/LOSE state and the restart pulse.
module fleet_engine #(
  parameter int          N_ENEMIES  = 8,
  parameter int          SHOT_DELAY = 1000000,
  parameter int          MOVE_DELAY = 500000,
  parameter int          X_START    = 16,
  parameter int          Y_START    = 16,
  parameter int          X_MIN      = 0,
  parameter int          X_MAX      = 200,
  parameter int          X_STEP     = 4,
  parameter int          Y_STEP     = 8,
  parameter int          Y_LOSE     = 180,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_restart_n,
  input  logic [N_ENEMIES-1:0] enemy_alive,
  input  logic                 player_alive,
  output logic                 restart,
  output logic [7:0]           block_x,
  output logic [7:0]           block_y,
  output logic [N_ENEMIES-1:0] shoot_id,
  output logic                 shoot_valid,
  output logic [1:0]           game_state
);

  localparam int SW = (SHOT_DELAY > 1) ? $clog2(SHOT_DELAY) : 1;
  localparam int MW = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;
  localparam int IW = $clog2(N_ENEMIES);

  typedef enum logic [1:0] {RUNNING = 2'd0, WIN = 2'd1, LOSE = 2'd2} state_t;

  // button synchronizer; idles high so a reset never looks like a press
  logic btn_s1, btn_s2, clear;
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
    end else begin
      btn_s1 <= btn_restart_n;
      btn_s2 <= btn_s1;
    end
  end
  assign clear = reset | ~btn_s2;

  // free-running; only reset reloads it so each restarted game differs
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // first alive enemy at or after start, wrapping: rotate, isolate lowest set bit, rotate back
  logic [IW-1:0]        start_idx;
  logic [N_ENEMIES-1:0] rot, pick, sel;
  always_comb begin
    start_idx = IW'(lfsr[7:0] % 8'(N_ENEMIES));
    rot       = N_ENEMIES'({enemy_alive, enemy_alive} >> start_idx);
    pick      = rot & (~rot + N_ENEMIES'(1));
    sel       = N_ENEMIES'(({pick, pick} << start_idx) >> N_ENEMIES);
  end

  state_t               state_q, state_d;
  logic                 dir_right_q, dir_right_d;
  logic [SW-1:0]        shot_cnt_q, shot_cnt_d;
  logic [MW-1:0]        move_cnt_q, move_cnt_d;
  logic [7:0]           x_q, x_d, y_q, y_d, y_sat;
  logic [N_ENEMIES-1:0] shoot_q, shoot_d;
  logic                 restart_q;
  logic                 running, lose_c, win_c, shot_tick, move_tick;
  logic [8:0]           x_inc, y_inc;

  always_comb begin
    state_d     = state_q;
    dir_right_d = dir_right_q;
    shot_cnt_d  = shot_cnt_q;
    move_cnt_d  = move_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    shoot_d     = '0;

    running   = (state_q == RUNNING);
    lose_c    = !player_alive || ({1'b0, y_q} >= 9'(Y_LOSE));
    win_c     = (enemy_alive == '0);
    shot_tick = running && (shot_cnt_q == SW'(SHOT_DELAY - 1));
    move_tick = running && (move_cnt_q == MW'(MOVE_DELAY - 1));
    x_inc     = {1'b0, x_q} + 9'(X_STEP);
    y_inc     = {1'b0, y_q} + 9'(Y_STEP);
    y_sat     = y_inc[8] ? 8'hFF : y_inc[7:0];

    if (clear) begin
      state_d     = RUNNING;
      dir_right_d = 1'b1;
      shot_cnt_d  = '0;
      move_cnt_d  = '0;
      x_d         = 8'(X_START);
      y_d         = 8'(Y_START);
    end else if (running) begin
      shot_cnt_d = shot_tick ? '0 : shot_cnt_q + SW'(1);
      move_cnt_d = move_tick ? '0 : move_cnt_q + MW'(1);
      if (move_tick) begin
        if (dir_right_q) begin
          if (x_inc > 9'(X_MAX)) begin
            y_d         = y_sat;
            dir_right_d = 1'b0;
          end else begin
            x_d = x_inc[7:0];
          end
        end else begin
          if ({1'b0, x_q} < 9'(X_MIN + X_STEP)) begin
            y_d         = y_sat;
            dir_right_d = 1'b1;
          end else begin
            x_d = x_q - 8'(X_STEP);
          end
        end
      end
      if (lose_c)     state_d = LOSE;
      else if (win_c) state_d = WIN;
      // a game that ends this cycle does not get a parting shot
      if (shot_tick && !lose_c && !win_c) shoot_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    dir_right_q <= dir_right_d;
    shot_cnt_q  <= shot_cnt_d;
    move_cnt_q  <= move_cnt_d;
    x_q         <= x_d;
    y_q         <= y_d;
    shoot_q     <= shoot_d;
    restart_q   <= clear;
  end

  assign restart     = restart_q;
  assign block_x     = x_q;
  assign block_y     = y_q;
  assign shoot_id    = shoot_q;
  assign shoot_valid = |shoot_q;
  assign game_state  = state_q;

endmodule
